// File: rtl/operand_stack_pkg.sv
// Shared definitions for the operand stack: opcodes and sticky error-bit indices.
package operand_stack_pkg;

    typedef enum logic [2:0] {
        STK_NOP       = 3'd0,
        STK_PUSH      = 3'd1,
        STK_POP       = 3'd2,
        STK_REPL      = 3'd3,
        STK_POP2_PUSH = 3'd4,
        STK_DUP       = 3'd5,
        STK_SWAP      = 3'd6,
        STK_CLEAR     = 3'd7
    } stk_op_e;

    localparam int STK_ERR_UNDER = 0;
    localparam int STK_ERR_OVER  = 1;

endpackage

// File: rtl/stack_regfile.sv
// DEPTH x DATA_W operand storage: two combinational read ports, two synchronous write ports.
module stack_regfile #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic [AW-1:0]     i_rd0_addr,
    output logic [DATA_W-1:0] o_rd0_data,
    input  logic [AW-1:0]     i_rd1_addr,
    output logic [DATA_W-1:0] o_rd1_data,
    input  logic              i_we0,
    input  logic [AW-1:0]     i_wa0,
    input  logic [DATA_W-1:0] i_wd0,
    input  logic              i_we1,
    input  logic [AW-1:0]     i_wa1,
    input  logic [DATA_W-1:0] i_wd1
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    assign o_rd0_data = r_mem[i_rd0_addr];
    assign o_rd1_data = r_mem[i_rd1_addr];

    // Callers never target the same address with both ports in one cycle.
    always_ff @(posedge clk) begin
        if (i_we0) r_mem[i_wa0] <= i_wd0;
        if (i_we1) r_mem[i_wa1] <= i_wd1;
    end

endmodule

// File: rtl/operand_stack.sv
// Hardware LIFO for the stack-machine controller: one-cycle stack primitives,
// combinational top/next-on-stack, overflow/underflow rejection with sticky flags.
module operand_stack
    import operand_stack_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] data_in,
    output logic              op_ack,
    output logic              op_err,
    output logic [DATA_W-1:0] tos,
    output logic [DATA_W-1:0] nos,
    output logic [PTR_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic [1:0]        err_sticky,
    input  logic              err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(DEPTH);

    logic [PTR_W-1:0]  r_sp;
    logic              r_ack;
    logic              r_err;
    logic [1:0]        r_sticky;

    logic [AW-1:0]     w_free_a, w_top_a, w_nos_a;
    logic [DATA_W-1:0] w_rd_top, w_rd_nos;
    logic              w_empty, w_full, w_ge2, w_go;
    logic              w_legal;
    logic [1:0]        w_err_set;
    logic [PTR_W-1:0]  w_sp_nxt;
    logic              w_we0, w_we1;
    logic [AW-1:0]     w_wa0, w_wa1;
    logic [DATA_W-1:0] w_wd0, w_wd1;

    assign w_free_a = r_sp[AW-1:0];
    assign w_top_a  = w_free_a - AW'(1);
    assign w_nos_a  = w_free_a - AW'(2);
    assign w_empty  = (r_sp == '0);
    assign w_full   = (r_sp == FULL_CNT);
    assign w_ge2    = (r_sp >= PTR_W'(2));
    assign w_go     = op_valid && !reset;

    always_comb begin
        w_legal   = 1'b1;
        w_err_set = '0;
        w_sp_nxt  = r_sp;
        w_we0     = 1'b0;
        w_wa0     = w_free_a;
        w_wd0     = data_in;
        w_we1     = 1'b0;
        w_wa1     = w_nos_a;
        w_wd1     = w_rd_top;
        case (stk_op_e'(op))
            STK_NOP: ;
            STK_PUSH:
                if (w_full) begin
                    w_legal = 1'b0;
                    w_err_set[STK_ERR_OVER] = 1'b1;
                end else begin
                    w_we0    = 1'b1;
                    w_sp_nxt = r_sp + PTR_W'(1);
                end
            STK_POP:
                if (w_empty) begin
                    w_legal = 1'b0;
                    w_err_set[STK_ERR_UNDER] = 1'b1;
                end else begin
                    w_sp_nxt = r_sp - PTR_W'(1);
                end
            STK_REPL:
                if (w_empty) begin
                    w_legal = 1'b0;
                    w_err_set[STK_ERR_UNDER] = 1'b1;
                end else begin
                    w_we0 = 1'b1;
                    w_wa0 = w_top_a;
                end
            STK_POP2_PUSH:
                if (!w_ge2) begin
                    w_legal = 1'b0;
                    w_err_set[STK_ERR_UNDER] = 1'b1;
                end else begin
                    w_we0    = 1'b1;
                    w_wa0    = w_nos_a;
                    w_sp_nxt = r_sp - PTR_W'(1);
                end
            STK_DUP:
                if (w_empty) begin
                    w_legal = 1'b0;
                    w_err_set[STK_ERR_UNDER] = 1'b1;
                end else if (w_full) begin
                    w_legal = 1'b0;
                    w_err_set[STK_ERR_OVER] = 1'b1;
                end else begin
                    w_we0    = 1'b1;
                    w_wd0    = w_rd_top;
                    w_sp_nxt = r_sp + PTR_W'(1);
                end
            STK_SWAP:
                if (!w_ge2) begin
                    w_legal = 1'b0;
                    w_err_set[STK_ERR_UNDER] = 1'b1;
                end else begin
                    w_we0 = 1'b1;
                    w_wa0 = w_top_a;
                    w_wd0 = w_rd_nos;
                    w_we1 = 1'b1;
                end
            STK_CLEAR:
                w_sp_nxt = '0;
        endcase
    end

    stack_regfile #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_regfile (
        .clk        (clk),
        .i_rd0_addr (w_top_a),
        .o_rd0_data (w_rd_top),
        .i_rd1_addr (w_nos_a),
        .o_rd1_data (w_rd_nos),
        .i_we0      (w_go && w_we0),
        .i_wa0      (w_wa0),
        .i_wd0      (w_wd0),
        .i_we1      (w_go && w_we1),
        .i_wa1      (w_wa1),
        .i_wd1      (w_wd1)
    );

    // A same-edge error sets its bit after err_clr has cleared the old ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sp     <= '0;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_sticky <= '0;
        end else begin
            r_ack    <= op_valid;
            r_err    <= op_valid && !w_legal;
            if (op_valid) r_sp <= w_sp_nxt;
            r_sticky <= (err_clr ? 2'b00 : r_sticky) | (op_valid ? w_err_set : 2'b00);
        end
    end

    assign op_ack     = r_ack;
    assign op_err     = r_err;
    assign count      = r_sp;
    assign empty      = w_empty;
    assign full       = w_full;
    assign err_sticky = r_sticky;
    assign tos        = w_empty ? '0 : w_rd_top;
    assign nos        = w_ge2   ? w_rd_nos : '0;

endmodule

// File: doc/operand_stack.md
Name: operand_stack

Overview:
- Hardware LIFO that serves the stack-machine controller's push/pop requests; the responder side of the controller's stack interface.
- Holds operands for ALU instructions, exposes the top two entries combinationally, and executes stack primitives in one cycle.
- Flags overflow/underflow instead of corrupting state.
- Sits between the CPU controller, the ALU operand inputs, and the values RAM write path.

Parameters:
- DATA_W, 8, operand width in bits.
- DEPTH, 16, number of entries; power of two, minimum 4.
- PTR_W, $clog2(DEPTH)+1, width of the stack pointer/count.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- op_valid  input  1  request strobe; sampled on posedge clk.
- op  input  3  operation code; see Behaviour.
- data_in  input  DATA_W  operand for PUSH, REPL and POP2_PUSH.
- op_ack  output  1  one-cycle pulse: the request accepted on the previous edge has completed.
- op_err  output  1  one-cycle pulse, coincident with op_ack, when the request was rejected.
- tos  output  DATA_W  top of stack; 0 when empty.
- nos  output  DATA_W  next-on-stack; 0 when count < 2.
- count  output  PTR_W  number of valid entries.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- err_sticky  output  2  bit0 = underflow seen, bit1 = overflow seen.
- err_clr  input  1  clears err_sticky.

Behaviour:
- Reset (synchronous, active-high, clk edge):
  - sp = 0, count = 0, op_ack = 0, op_err = 0, err_sticky = 0.
  - Storage contents are don't-care; tos and nos read 0.
- Storage: DEPTH x DATA_W register array. sp points to the next free slot, so tos = mem[sp-1] and nos = mem[sp-2]. Both are combinational reads of registered state.
- No backpressure: a request is accepted on every edge where op_valid=1.
- Latency: 1 cycle. State and outputs are updated at the accepting edge; op_ack is high for exactly the following cycle.
- op_valid held high for N cycles means N back-to-back operations.
- Op codes:
  - 0 NOP: ack only.
  - 1 PUSH: mem[sp] = data_in, sp+1. Requires !full.
  - 2 POP: sp-1. Requires count ≥ 1.
  - 3 REPL: mem[sp-1] = data_in, sp unchanged. Requires count ≥ 1.
  - 4 POP2_PUSH: mem[sp-2] = data_in, sp-1. Requires count ≥ 2. Used for binary ALU results.
  - 5 DUP: mem[sp] = mem[sp-1], sp+1. Requires 1 ≤ count < DEPTH.
  - 6 SWAP: exchange mem[sp-1] and mem[sp-2]. Requires count ≥ 2.
  - 7 CLEAR: sp = 0. Always legal.
- Rejected op (precondition failed):
  - Storage and sp are unchanged.
  - op_ack=1 and op_err=1 in the next cycle.
  - Sets err_sticky bit0 (underflow: POP, REPL, POP2_PUSH, SWAP, DUP on empty) or bit1 (overflow: PUSH, DUP on full).
- err_sticky:
  - Bits hold until err_clr or reset.
  - If err_clr and a new error land on the same edge, the new error bit wins (set after clear).
- count wraps never; bounded 0..DEPTH by the rejection rules above.
- reset while op_valid=1: reset wins; the request is dropped and no ack follows.
- data_in is ignored for ops that do not use it.

Decomposition:
- Shared package (alongside the existing opcode/state definitions):
  - op-code constants STK_NOP..STK_CLEAR.
  - error-bit indices STK_ERR_UNDER = 0, STK_ERR_OVER = 1.
- One sub-module is natural: stack_regfile. It holds the DEPTH x DATA_W array, with two combinational read ports (addr sp-1, sp-2) and two synchronous write ports (needed for SWAP).
- operand_stack keeps sp, the op decode/legality logic, ack/err and the sticky flags.

Test Plan:
- Reset, then PUSH 0x11, PUSH 0x22, PUSH 0x33 back-to-back -> op_ack high 3 consecutive cycles; final tos=0x33, nos=0x22, count=3, op_err never set.
- From [0x11,0x22,0x33]: POP2_PUSH data_in=0x55 -> tos=0x55, nos=0x11, count=2; then SWAP -> tos=0x11, nos=0x55.
- From empty: POP -> op_ack=1, op_err=1, count=0, err_sticky=01; then err_clr -> err_sticky=00.
- Fill 16 PUSHes (0x00..0x0F) -> full=1, tos=0x0F; then PUSH 0xAA and DUP -> both rejected, err_sticky=10, tos=0x0F, count=16.
- From [0x07]: DUP then REPL 0x09 -> count=2, tos=0x09, nos=0x07; CLEAR -> empty=1, tos=0, nos=0.
- PUSH 0x44 accepted with reset asserted on the same edge -> no op_ack, count=0, tos=0.
